// File: rtl/eth_rx_noc_out_steer_if.sv
// Handshake bundle for the Ethernet RX NoC output stage: header, payload,
// NoC flit and CAM lookup channels. "master" is the steering block's view.
interface eth_rx_noc_out_steer_if #(
  parameter int DATA_W     = 512,
  parameter int HDR_W      = 112,
  parameter int MTU_SIZE_W = 16,
  parameter int ETH_TYPE_W = 16,
  parameter int XY_WIDTH   = 8
);
  localparam int PAD_W = $clog2(DATA_W / 8);

  logic                  in_hdr_val;
  logic [HDR_W-1:0]      in_hdr;
  logic [MTU_SIZE_W-1:0] in_data_size;
  logic                  in_hdr_rdy;

  logic                  in_data_val;
  logic [DATA_W-1:0]     in_data;
  logic                  in_data_last;
  logic [PAD_W-1:0]      in_data_padbytes;
  logic                  in_data_rdy;

  logic                  noc_out_val;
  logic [DATA_W-1:0]     noc_out_data;
  logic                  noc_out_rdy;

  logic [ETH_TYPE_W-1:0] cam_rd_tag;
  logic                  cam_rd_hit;
  logic [2*XY_WIDTH-1:0] cam_rd_data;

  modport master (
    input  in_hdr_val, in_hdr, in_data_size,
    output in_hdr_rdy,
    input  in_data_val, in_data, in_data_last, in_data_padbytes,
    output in_data_rdy,
    output noc_out_val, noc_out_data,
    input  noc_out_rdy,
    output cam_rd_tag,
    input  cam_rd_hit, cam_rd_data
  );

  modport slave (
    output in_hdr_val, in_hdr, in_data_size,
    input  in_hdr_rdy,
    output in_data_val, in_data, in_data_last, in_data_padbytes,
    input  in_data_rdy,
    input  noc_out_val, noc_out_data,
    output noc_out_rdy,
    input  cam_rd_tag,
    output cam_rd_hit, cam_rd_data
  );
endinterface

// File: rtl/eth_rx_noc_out_steer.sv
// Ethernet RX tile output stage: turns one parsed header plus payload stream
// into a NoC message (header flit, metadata flit, data flits); CAM misses are dropped.
module eth_rx_noc_out_steer #(
  parameter int SRC_X      = -1,
  parameter int SRC_Y      = -1,
  parameter int DATA_W     = 512,
  parameter int TS_W       = 64,
  parameter int DROP_CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  eth_rx_noc_out_steer_if.master bus,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam int XY_WIDTH         = 8;
  localparam int MTU_SIZE_W       = 16;
  localparam int ETH_TYPE_W       = 16;
  localparam int MAC_W            = 48;
  localparam int HDR_W            = 2 * MAC_W + ETH_TYPE_W;
  localparam int MSG_LENGTH_WIDTH = 8;
  localparam int MSG_TYPE_W       = 8;
  localparam int MSG_TIMESTAMP_W  = 64;
  localparam int FBITS_W          = 4;
  localparam int META_FLITS_W     = 8;
  localparam int BYTES            = DATA_W / 8;
  localparam int BYTES_LOG        = $clog2(BYTES);

  localparam logic [FBITS_W-1:0]      PKT_IF_FBITS   = 4'd2;
  localparam logic [MSG_TYPE_W-1:0]   IP_RX_DATAGRAM = 8'd17;
  localparam logic [ETH_TYPE_W-1:0]   ETH_TYPE_IPV4  = 16'h0800;
  localparam logic [XY_WIDTH-1:0]     SRC_X_L        = XY_WIDTH'(SRC_X);
  localparam logic [XY_WIDTH-1:0]     SRC_Y_L        = XY_WIDTH'(SRC_Y);
  localparam logic [META_FLITS_W-1:0] META_FLITS     = 8'd1;

  // Header flit field MSBs, packed from the top of the flit down
  localparam int H_DX   = DATA_W - 1;
  localparam int H_DY   = H_DX - XY_WIDTH;
  localparam int H_FB   = H_DY - XY_WIDTH;
  localparam int H_LEN  = H_FB - FBITS_W;
  localparam int H_TYPE = H_LEN - MSG_LENGTH_WIDTH;
  localparam int H_SX   = H_TYPE - MSG_TYPE_W;
  localparam int H_SY   = H_SX - XY_WIDTH;
  localparam int H_MF   = H_SY - XY_WIDTH;
  localparam int M_DST  = DATA_W - 1;
  localparam int M_SRC  = M_DST - MAC_W;
  localparam int M_LEN  = M_SRC - MAC_W;
  localparam int M_TS   = M_LEN - MTU_SIZE_W;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] HDR  = 3'd1;
  localparam logic [2:0] META = 3'd2;
  localparam logic [2:0] DATA = 3'd3;
  localparam logic [2:0] DROP = 3'd4;

  logic [2:0]            state_r;
  logic [2:0]            state_nxt_s;
  logic [HDR_W-1:0]      hdr_r;
  logic [MTU_SIZE_W-1:0] size_r;
  logic [2*XY_WIDTH-1:0] dst_r;
  logic [TS_W-1:0]       ts_r;
  logic [TS_W-1:0]       ts_lat_r;
  logic [DROP_CNT_W-1:0] drop_cnt_r;

  logic                        hdr_hs_s;
  logic                        data_hs_s;
  logic                        in_hdr_rdy_s;
  logic                        in_data_rdy_s;
  logic                        noc_out_val_s;
  logic [DATA_W-1:0]           noc_out_data_s;
  logic [MTU_SIZE_W:0]         size_round_s;
  logic [MTU_SIZE_W:0]         data_flits_s;
  logic [MSG_LENGTH_WIDTH-1:0] msg_len_s;
  logic [MSG_TYPE_W-1:0]       msg_type_s;
  logic [DATA_W-1:0]           hdr_flit_s;
  logic [DATA_W-1:0]           meta_flit_s;
  logic [DATA_W-1:0]           data_masked_s;

  assign hdr_hs_s  = (state_r == IDLE) && bus.in_hdr_val;
  assign data_hs_s = bus.in_data_val && in_data_rdy_s;

  assign bus.cam_rd_tag   = bus.in_hdr[ETH_TYPE_W-1:0];
  assign bus.in_hdr_rdy   = in_hdr_rdy_s;
  assign bus.in_data_rdy  = in_data_rdy_s;
  assign bus.noc_out_val  = noc_out_val_s;
  assign bus.noc_out_data = noc_out_data_s;
  assign drop_cnt         = drop_cnt_r;

  // Ceiling division by the flit byte count, one extra bit so a full MTU cannot wrap
  assign size_round_s = {1'b0, size_r} + (MTU_SIZE_W + 1)'(BYTES - 1);
  assign data_flits_s = size_round_s >> BYTES_LOG;
  assign msg_len_s    = MSG_LENGTH_WIDTH'(data_flits_s) + MSG_LENGTH_WIDTH'(1);
  assign msg_type_s   = (hdr_r[ETH_TYPE_W-1:0] == ETH_TYPE_IPV4) ? IP_RX_DATAGRAM : 8'd0;

  // Free-running timestamp, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_r <= '0;
    end else begin
      ts_r <= ts_r + TS_W'(1);
    end
  end

  // Control FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Per-frame context captured on the header handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_r    <= '0;
      size_r   <= '0;
      dst_r    <= '0;
      ts_lat_r <= '0;
    end else if (hdr_hs_s) begin
      hdr_r    <= bus.in_hdr;
      size_r   <= bus.in_data_size;
      dst_r    <= bus.cam_rd_data;
      ts_lat_r <= ts_r;
    end else begin
      hdr_r    <= hdr_r;
      size_r   <= size_r;
      dst_r    <= dst_r;
      ts_lat_r <= ts_lat_r;
    end
  end

  // Saturating count of frames dropped on CAM miss
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_r <= '0;
    end else if (hdr_hs_s && !bus.cam_rd_hit && (drop_cnt_r != {DROP_CNT_W{1'b1}})) begin
      drop_cnt_r <= drop_cnt_r + DROP_CNT_W'(1);
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.in_hdr_val) begin
          state_nxt_s = bus.cam_rd_hit ? HDR : DROP;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      HDR: begin
        if (bus.noc_out_rdy) begin
          state_nxt_s = META;
        end else begin
          state_nxt_s = HDR;
        end
      end
      META: begin
        if (bus.noc_out_rdy) begin
          state_nxt_s = (size_r != '0) ? DATA : IDLE;
        end else begin
          state_nxt_s = META;
        end
      end
      DATA: begin
        if (data_hs_s && bus.in_data_last) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DATA;
        end
      end
      DROP: begin
        // An empty dropped frame has no beats to wait for
        if ((size_r == '0) || (data_hs_s && bus.in_data_last)) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DROP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Header and metadata flit assembly from the latched frame context
  always_comb begin
    hdr_flit_s = '0;
    hdr_flit_s[H_DX -: XY_WIDTH]           = dst_r[2*XY_WIDTH-1 -: XY_WIDTH];
    hdr_flit_s[H_DY -: XY_WIDTH]           = dst_r[XY_WIDTH-1:0];
    hdr_flit_s[H_FB -: FBITS_W]            = PKT_IF_FBITS;
    hdr_flit_s[H_LEN -: MSG_LENGTH_WIDTH]  = msg_len_s;
    hdr_flit_s[H_TYPE -: MSG_TYPE_W]       = msg_type_s;
    hdr_flit_s[H_SX -: XY_WIDTH]           = SRC_X_L;
    hdr_flit_s[H_SY -: XY_WIDTH]           = SRC_Y_L;
    hdr_flit_s[H_MF -: META_FLITS_W]       = META_FLITS;
    meta_flit_s = '0;
    meta_flit_s[M_DST -: MAC_W]            = hdr_r[HDR_W-1 -: MAC_W];
    meta_flit_s[M_SRC -: MAC_W]            = hdr_r[HDR_W-MAC_W-1 -: MAC_W];
    meta_flit_s[M_LEN -: MTU_SIZE_W]       = size_r;
    meta_flit_s[M_TS -: MSG_TIMESTAMP_W]   = MSG_TIMESTAMP_W'(ts_lat_r);
  end

  // Zero the padding bytes of the last beat; byte 0 sits in the top bits
  always_comb begin
    data_masked_s = '0;
    for (int i = 0; i < BYTES; i++) begin
      if (bus.in_data_last && (i >= (BYTES - int'(bus.in_data_padbytes)))) begin
        data_masked_s[DATA_W-1-8*i -: 8] = 8'h00;
      end else begin
        data_masked_s[DATA_W-1-8*i -: 8] = bus.in_data[DATA_W-1-8*i -: 8];
      end
    end
  end

  // Handshake outputs decoded from state; DATA is a straight pass-through
  always_comb begin
    in_hdr_rdy_s   = 1'b0;
    in_data_rdy_s  = 1'b0;
    noc_out_val_s  = 1'b0;
    noc_out_data_s = '0;
    case (state_r)
      IDLE: begin
        in_hdr_rdy_s = 1'b1;
      end
      HDR: begin
        noc_out_val_s  = 1'b1;
        noc_out_data_s = hdr_flit_s;
      end
      META: begin
        noc_out_val_s  = 1'b1;
        noc_out_data_s = meta_flit_s;
      end
      DATA: begin
        in_data_rdy_s  = bus.noc_out_rdy;
        noc_out_val_s  = bus.in_data_val;
        noc_out_data_s = data_masked_s;
      end
      DROP: begin
        in_data_rdy_s = (size_r != '0);
      end
      default: begin
        in_hdr_rdy_s = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_eth_rx_noc_out_steer.sv
// Scoreboard bench for eth_rx_noc_out_steer: directed frames push expected
// flits into a queue, a negedge monitor pops and compares every NoC handshake.
module tb_eth_rx_noc_out_steer;
  localparam int DATA_W = 512;

  typedef struct {
    logic [DATA_W-1:0] d;
    int                kind;
    string             name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] drop_cnt;
  logic [63:0] tb_ts;
  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          rdy_mode = 0;
  bit          chk_mirror = 1'b0;
  bit          watch_rdy = 1'b0;
  int          rdy_seen = 0;

  always #5 clk = ~clk;

  eth_rx_noc_out_steer_if #(.DATA_W(DATA_W)) bus ();

  eth_rx_noc_out_steer #(
    .SRC_X(5), .SRC_Y(6), .DATA_W(DATA_W), .TS_W(64), .DROP_CNT_W(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .drop_cnt(drop_cnt)
  );

  // External CAM model: EtherType -> {dst_x, dst_y}
  always_comb begin
    bus.cam_rd_hit  = 1'b0;
    bus.cam_rd_data = 16'hDEAD;
    case (bus.cam_rd_tag)
      16'h0800: begin bus.cam_rd_hit = 1'b1; bus.cam_rd_data = {8'd2, 8'd3}; end
      16'h0806: begin bus.cam_rd_hit = 1'b1; bus.cam_rd_data = {8'd1, 8'd4}; end
      16'h86DD: begin bus.cam_rd_hit = 1'b1; bus.cam_rd_data = {8'd7, 8'd1}; end
      default:  begin bus.cam_rd_hit = 1'b0; bus.cam_rd_data = 16'hDEAD; end
    endcase
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_ts <= 64'd0;
    else        tb_ts <= tb_ts + 64'd1;
  end

  // NoC sink ready pattern
  initial begin
    bus.noc_out_rdy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.noc_out_rdy = 1'b1;
        1:       bus.noc_out_rdy = ~bus.noc_out_rdy;
        default: bus.noc_out_rdy = 1'b0;
      endcase
    end
  end

  // Monitor: compare each flit that will be accepted at the next rising edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (chk_mirror && (exp_q.size() > 0) && (exp_q[0].kind == 2) && bus.in_data_val) begin
          checks++;
          if (bus.in_data_rdy !== bus.noc_out_rdy) begin
            errors++;
            $display("FAIL mirror: in_data_rdy=%b noc_out_rdy=%b", bus.in_data_rdy, bus.noc_out_rdy);
          end
        end
        if (watch_rdy && bus.in_data_rdy) rdy_seen++;
        if (bus.noc_out_val && bus.noc_out_rdy) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_flit: got %h required none", bus.noc_out_data);
          end else begin
            e = exp_q.pop_front();
            if (bus.noc_out_data !== e.d) begin
              errors++;
              $display("FAIL %s: got %h required %h", e.name, bus.noc_out_data, e.d);
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, want);
    end
  endtask

  function automatic logic [DATA_W-1:0] beat_pat(input logic [23:0] seed, input int b);
    logic [31:0] w;
    w = {seed, 8'(b)};
    return {16{w}};
  endfunction

  function automatic logic [DATA_W-1:0] mask_low(input logic [DATA_W-1:0] d, input int pad);
    for (int i = 0; i < pad * 8; i++) d[i] = 1'b0;
    return d;
  endfunction

  function automatic logic [DATA_W-1:0] hdr_flit(input logic [7:0] dx, input logic [7:0] dy,
                                                 input logic [7:0] len, input logic [7:0] mtype);
    logic [DATA_W-1:0] f;
    f = '0;
    f[511:504] = dx;   f[503:496] = dy;   f[495:492] = 4'd2;  f[491:484] = len;
    f[483:476] = mtype; f[475:468] = 8'd5; f[467:460] = 8'd6; f[459:452] = 8'd1;
    return f;
  endfunction

  function automatic logic [DATA_W-1:0] meta_flit(input logic [47:0] dmac, input logic [47:0] smac,
                                                  input logic [15:0] size, input logic [63:0] ts);
    logic [DATA_W-1:0] f;
    f = '0;
    f[511:464] = dmac; f[463:416] = smac; f[415:400] = size; f[399:336] = ts;
    return f;
  endfunction

  task automatic send_hdr(input logic [15:0] etype, input logic [15:0] size, input int nbeats,
                          input int pad, input bit hit, input logic [7:0] dx, input logic [7:0] dy,
                          input logic [7:0] len, input logic [7:0] mtype, input logic [23:0] seed);
    logic [47:0] dmac;
    logic [47:0] smac;
    logic [DATA_W-1:0] d;
    bit hs;
    dmac = {seed, 24'h112233};
    smac = {24'h445566, seed};
    @(posedge clk);
    #1;
    bus.in_hdr = {dmac, smac, etype};
    bus.in_data_size = size;
    bus.in_hdr_val = 1'b1;
    hs = 1'b0;
    for (int k = 0; (k < 100) && !hs; k++) begin
      @(negedge clk);
      if (bus.in_hdr_rdy) begin
        hs = 1'b1;
        if (hit) begin
          exp_q.push_back('{hdr_flit(dx, dy, len, mtype), 0, "hdr_flit"});
          exp_q.push_back('{meta_flit(dmac, smac, size, tb_ts), 1, "meta_flit"});
          for (int b = 0; b < nbeats; b++) begin
            d = beat_pat(seed, b);
            if (b == nbeats - 1) d = mask_low(d, pad);
            exp_q.push_back('{d, 2, "data_flit"});
          end
        end
      end
      @(posedge clk);
      #1;
    end
    bus.in_hdr_val = 1'b0;
    if (!hs) chk("hdr_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_beats(input int nbeats, input int pad, input logic [23:0] seed);
    bit hs;
    for (int b = 0; b < nbeats; b++) begin
      bus.in_data_val = 1'b1;
      bus.in_data = beat_pat(seed, b);
      bus.in_data_last = (b == nbeats - 1);
      bus.in_data_padbytes = (b == nbeats - 1) ? 6'(pad) : 6'd5;
      hs = 1'b0;
      for (int k = 0; (k < 100) && !hs; k++) begin
        @(negedge clk);
        if (bus.in_data_rdy) hs = 1'b1;
        @(posedge clk);
        #1;
      end
      if (!hs) chk("beat_timeout", 64'd0, 64'd1);
    end
    bus.in_data_val = 1'b0;
    bus.in_data_last = 1'b0;
    bus.in_data_padbytes = 6'd0;
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; (k < 200) && (exp_q.size() != 0); k++) @(negedge clk);
    chk(name, 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.in_hdr_val = 1'b0;
    bus.in_hdr = '0;
    bus.in_data_size = '0;
    bus.in_data_val = 1'b0;
    bus.in_data = '0;
    bus.in_data_last = 1'b0;
    bus.in_data_padbytes = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_hdr_rdy", 64'(bus.in_hdr_rdy), 64'd1);
    chk("rst_in_data_rdy", 64'(bus.in_data_rdy), 64'd0);
    chk("rst_noc_out_val", 64'(bus.noc_out_val), 64'd0);
    chk("rst_noc_out_data", 64'(bus.noc_out_data != '0), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Payload with no header must not be consumed
    bus.in_data_val = 1'b1;
    bus.in_data = beat_pat(24'h5A5A5A, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("idle_in_data_rdy", 64'(bus.in_data_rdy), 64'd0);
    bus.in_data_val = 1'b0;

    // IPv4 100 B hit (2,3): msg_len 3, two data flits, 28 pad bytes
    send_hdr(16'h0800, 16'd100, 2, 28, 1'b1, 8'd2, 8'd3, 8'd3, 8'd17, 24'hA10000);
    send_beats(2, 28, 24'hA10000);
    wait_drain("ipv4_100_drain");

    // ARP 64 B hit (1,4): exact multiple, msg_len 2, type 0
    send_hdr(16'h0806, 16'd64, 1, 0, 1'b1, 8'd1, 8'd4, 8'd2, 8'd0, 24'hB20000);
    send_beats(1, 0, 24'hB20000);
    wait_drain("arp_64_drain");

    // CAM miss, 200 B in 4 beats: consumed silently and counted
    send_hdr(16'h88CC, 16'd200, 4, 56, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 24'hC30000);
    send_beats(4, 56, 24'hC30000);
    wait_drain("miss_drain");
    chk("drop_cnt_after_miss", 64'(drop_cnt), 64'd1);

    send_hdr(16'h0800, 16'd100, 2, 28, 1'b1, 8'd2, 8'd3, 8'd3, 8'd17, 24'hD40000);
    send_beats(2, 28, 24'hD40000);
    wait_drain("after_miss_drain");

    // 150 B over 3 beats with noc_out_rdy toggling every cycle
    rdy_mode = 1;
    chk_mirror = 1'b1;
    send_hdr(16'h0800, 16'd150, 3, 42, 1'b1, 8'd2, 8'd3, 8'd4, 8'd17, 24'hE50000);
    send_beats(3, 42, 24'hE50000);
    wait_drain("toggle_drain");
    chk_mirror = 1'b0;
    rdy_mode = 0;

    // Empty frame: header + metadata only, payload side never ready
    watch_rdy = 1'b1;
    rdy_seen = 0;
    send_hdr(16'h86DD, 16'd0, 0, 0, 1'b1, 8'd7, 8'd1, 8'd1, 8'd0, 24'hF60000);
    wait_drain("size0_drain");
    repeat (3) @(posedge clk);
    watch_rdy = 1'b0;
    chk("size0_in_data_rdy_seen", 64'(rdy_seen), 64'd0);
    chk("drop_cnt_before_rst", 64'(drop_cnt), 64'd1);

    // Reset in the middle of DATA with the sink stalled
    send_hdr(16'h0800, 16'd100, 2, 28, 1'b1, 8'd2, 8'd3, 8'd3, 8'd17, 24'h170000);
    for (int k = 0; (k < 100) && (exp_q.size() > 2); k++) @(negedge clk);
    rdy_mode = 2;
    @(posedge clk);
    #1;
    bus.in_data_val = 1'b1;
    bus.in_data = beat_pat(24'h170000, 0);
    bus.in_data_last = 1'b0;
    @(negedge clk);
    chk("mid_data_noc_out_val", 64'(bus.noc_out_val), 64'd1);
    chk("mid_data_in_data_rdy", 64'(bus.in_data_rdy), 64'd0);
    chk("mid_data_passthru", 64'(bus.noc_out_data == beat_pat(24'h170000, 0)), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_noc_out_val", 64'(bus.noc_out_val), 64'd0);
    chk("rst_mid_in_data_rdy", 64'(bus.in_data_rdy), 64'd0);
    chk("rst_mid_in_hdr_rdy", 64'(bus.in_hdr_rdy), 64'd1);
    chk("rst_mid_drop_cnt", 64'(drop_cnt), 64'd0);
    exp_q.delete();
    bus.in_data_val = 1'b0;
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    send_hdr(16'h0800, 16'd100, 2, 28, 1'b1, 8'd2, 8'd3, 8'd3, 8'd17, 24'h280000);
    send_beats(2, 28, 24'h280000);
    wait_drain("post_rst_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
